// File: rtl/ace_snoop_issuer_pkg.sv
// Shared types, state encodings and CR/err bit positions for the ACE snoop issuer.
package ace_snoop_issuer_pkg;

  localparam int CMD_ADDR_W = 64;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [3:0]            snoop;
  } cmd_t;

  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE = 2'd0;
  localparam state_e ST_AC   = 2'd1;
  localparam state_e ST_RESP = 2'd2;
  localparam state_e ST_DONE = 2'd3;

  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;

  localparam int ERR_UNEXP = 0;
  localparam int ERR_BEATS = 1;
  localparam int ERR_TMO   = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ace_snoop_cmd_fifo.sv
// Small command FIFO for pending snoops; push is ignored when full, pop when empty.
module ace_snoop_cmd_fifo
  import ace_snoop_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic          do_push_s, do_pop_s;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    do_push_s = push_i & ~full_o;
    do_pop_s  = pop_i & ~empty_o;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ace_snoop_issuer.sv
// Issues queued ACE snoops on AC one at a time, gathers CR/CD and reports one result per snoop.
// Optional line capture output done_line_o is enabled by ACE_SNOOP_ISSUER_CD_CAPTURE_EN.
module ace_snoop_issuer
  import ace_snoop_issuer_pkg::*;
#(
  parameter int CMD_DEPTH         = 4,
  parameter int ADDR_WIDTH        = 64,
  parameter int DATA_WIDTH        = 64,
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int LINE_BEATS        = DCACHE_LINE_WIDTH / 64,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [3:0]            cmd_snoop_i,
  output logic                  ac_valid_o,
  input  logic                  ac_ready_i,
  output logic [ADDR_WIDTH-1:0] ac_addr_o,
  output logic [3:0]            ac_snoop_o,
  input  logic                  cr_valid_i,
  output logic                  cr_ready_o,
  input  logic [4:0]            cr_resp_i,
  input  logic                  cd_valid_i,
  output logic                  cd_ready_o,
  input  logic [DATA_WIDTH-1:0] cd_data_i,
  input  logic                  cd_last_i,
  output logic                  done_o,
  output logic [4:0]            done_resp_o,
  output logic [7:0]            done_beats_o,
  output logic                  busy_o,
`ifdef ACE_SNOOP_ISSUER_CD_CAPTURE_EN
  output logic [LINE_BEATS*DATA_WIDTH-1:0] done_line_o,
`endif
  output logic [2:0]            err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  cmd_t push_cmd_s, head_cmd_s;
  logic fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic cr_hs_s, cd_hs_s, dt_s, complete_s, timeout_s;

  state_e                state_q, state_d;
  logic                  ac_valid_q, ac_valid_d;
  logic [ADDR_WIDTH-1:0] ac_addr_q, ac_addr_d;
  logic [3:0]            ac_snoop_q, ac_snoop_d;
  logic                  cr_ready_q, cr_ready_d, cd_ready_q, cd_ready_d;
  logic                  cr_seen_q, cr_seen_d, last_seen_q, last_seen_d;
  logic                  nodata_q, nodata_d;
  logic [4:0]            resp_q, resp_d, done_resp_q, done_resp_d;
  logic [7:0]            beats_q, beats_d, done_beats_q, done_beats_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  done_q, done_d;
  logic [2:0]            err_q, err_d;

  always_comb begin
    push_cmd_s.addr  = CMD_ADDR_W'(cmd_addr_i);
    push_cmd_s.snoop = cmd_snoop_i;
  end

  ace_snoop_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .data_i  (push_cmd_s),
    .pop_i   (fifo_pop_s),
    .data_o  (head_cmd_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign cr_hs_s = cr_valid_i & cr_ready_q;
  assign cd_hs_s = cd_valid_i & cd_ready_q;

  // Snoop sequencing, response collection and error flags
  always_comb begin
    state_d      = state_q;
    ac_valid_d   = ac_valid_q;
    ac_addr_d    = ac_addr_q;
    ac_snoop_d   = ac_snoop_q;
    cr_ready_d   = cr_ready_q;
    cd_ready_d   = cd_ready_q;
    cr_seen_d    = cr_seen_q;
    last_seen_d  = last_seen_q;
    nodata_d     = nodata_q;
    resp_d       = resp_q;
    beats_d      = beats_q;
    timer_d      = timer_q;
    done_d       = 1'b0;
    done_resp_d  = done_resp_q;
    done_beats_d = done_beats_q;
    err_d        = err_q;
    fifo_pop_s   = 1'b0;
    dt_s         = resp_q[CR_DT];
    complete_s   = 1'b0;
    timeout_s    = 1'b0;
    // Any CD activity after a no-data CR is a protocol violation, even once the snoop has retired
    err_d[ERR_UNEXP] = err_q[ERR_UNEXP] | (cd_valid_i & nodata_q);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          ac_addr_d  = head_cmd_s.addr[ADDR_WIDTH-1:0];
          ac_snoop_d = head_cmd_s.snoop;
          ac_valid_d = 1'b1;
          state_d    = ST_AC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AC: begin
        if (ac_ready_i) begin
          ac_valid_d  = 1'b0;
          cr_seen_d   = 1'b0;
          last_seen_d = 1'b0;
          nodata_d    = 1'b0;
          beats_d     = 8'd0;
          timer_d     = '0;
          cr_ready_d  = 1'b1;
          cd_ready_d  = 1'b1;
          state_d     = ST_RESP;
        end else begin
          ac_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        cr_seen_d   = cr_seen_q | cr_hs_s;
        resp_d      = cr_hs_s ? cr_resp_i : resp_q;
        beats_d     = cd_hs_s ? sat_inc8(beats_q) : beats_q;
        last_seen_d = last_seen_q | (cd_hs_s & cd_last_i);
        nodata_d    = nodata_q | (cr_hs_s & ~cr_resp_i[CR_DT]);
        timer_d     = timer_q + 1'b1;
        dt_s        = resp_d[CR_DT];
        err_d[ERR_UNEXP] = err_d[ERR_UNEXP] | (cr_hs_s & ~cr_resp_i[CR_DT] & (beats_d != 8'd0));
        err_d[ERR_BEATS] = err_q[ERR_BEATS] | (cd_hs_s & cd_last_i & (beats_d != 8'(LINE_BEATS)));
        complete_s  = cr_seen_d & (~dt_s | last_seen_d);
        timeout_s   = ~complete_s & (timer_q == TW'(TIMEOUT_CYCLES - 1));
        if (complete_s || timeout_s) begin
          state_d        = ST_DONE;
          done_d         = 1'b1;
          done_resp_d    = resp_d;
          done_beats_d   = beats_d;
          cr_ready_d     = 1'b0;
          cd_ready_d     = 1'b0;
          err_d[ERR_TMO] = err_q[ERR_TMO] | timeout_s;
        end else begin
          cr_ready_d = ~cr_seen_d;
          cd_ready_d = ~last_seen_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ac_valid_q   <= 1'b0;
      ac_addr_q    <= '0;
      ac_snoop_q   <= 4'd0;
      cr_ready_q   <= 1'b0;
      cd_ready_q   <= 1'b0;
      cr_seen_q    <= 1'b0;
      last_seen_q  <= 1'b0;
      nodata_q     <= 1'b0;
      resp_q       <= 5'd0;
      beats_q      <= 8'd0;
      timer_q      <= '0;
      done_q       <= 1'b0;
      done_resp_q  <= 5'd0;
      done_beats_q <= 8'd0;
      err_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      ac_valid_q   <= ac_valid_d;
      ac_addr_q    <= ac_addr_d;
      ac_snoop_q   <= ac_snoop_d;
      cr_ready_q   <= cr_ready_d;
      cd_ready_q   <= cd_ready_d;
      cr_seen_q    <= cr_seen_d;
      last_seen_q  <= last_seen_d;
      nodata_q     <= nodata_d;
      resp_q       <= resp_d;
      beats_q      <= beats_d;
      timer_q      <= timer_d;
      done_q       <= done_d;
      done_resp_q  <= done_resp_d;
      done_beats_q <= done_beats_d;
      err_q        <= err_d;
    end
  end

`ifdef ACE_SNOOP_ISSUER_CD_CAPTURE_EN
  logic [LINE_BEATS*DATA_WIDTH-1:0] line_q, line_d, done_line_q, done_line_d;

  // Beats past the end of the line are dropped rather than wrapped
  always_comb begin
    line_d      = line_q;
    done_line_d = done_line_q;
    if (cd_hs_s && (beats_q < 8'(LINE_BEATS))) begin
      line_d[beats_q*DATA_WIDTH +: DATA_WIDTH] = cd_data_i;
    end else begin
      line_d = line_q;
    end
    if (done_d) begin
      done_line_d = line_d;
    end else begin
      done_line_d = done_line_q;
    end
  end

  // Line capture registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q      <= '0;
      done_line_q <= '0;
    end else begin
      line_q      <= line_d;
      done_line_q <= done_line_d;
    end
  end

  assign done_line_o = done_line_q;
`else
  logic unused_cd_data_s;
  assign unused_cd_data_s = ^cd_data_i;
`endif

  assign cmd_ready_o  = ~fifo_full_s;
  assign ac_valid_o   = ac_valid_q;
  assign ac_addr_o    = ac_addr_q;
  assign ac_snoop_o   = ac_snoop_q;
  assign cr_ready_o   = cr_ready_q;
  assign cd_ready_o   = cd_ready_q;
  assign done_o       = done_q;
  assign done_resp_o  = done_resp_q;
  assign done_beats_o = done_beats_q;
  assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign err_o        = err_q;

endmodule
